// File: rtl/ijtc_update_scheduler.sv
// ijtc_update_scheduler: owns the IJTC target RAM port, sweeps it invalid after reset,
// arbitrates fetch lookups against queued repair writes, and maintains the Gshare GHR.
module ijtc_update_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int GHR_LEN    = 8,
    parameter int IDX_W      = 8,
    parameter int STARVE_MAX = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lookup_req_i,
    input  logic [31:0]         lookup_pc_i,
    output logic                lookup_grant_o,
    input  logic                spec_valid_i,
    input  logic                spec_take_i,
    input  logic                rep_valid_i,
    output logic                rep_ready_o,
    input  logic [31:0]         rep_pc_i,
    input  logic [31:0]         rep_dest_i,
    input  logic                rep_take_i,
    input  logic [GHR_LEN-1:0]  rep_ghr_i,
    output logic [GHR_LEN-1:0]  ghr_o,
    output logic                ram_en_o,
    output logic                ram_we_o,
    output logic [IDX_W-1:0]    ram_idx_o,
    output logic [29-IDX_W:0]   ram_wtag_o,
    output logic [31:0]         ram_wdata_o,
    output logic                ram_wvalid_o,
    output logic                busy_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   init_cnt_q;
    logic [GHR_LEN-1:0] ghr_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [SW-1:0]      starve_q;

    // Repair queue storage; pc keeps only bits [31:2], the low bits never reach the RAM.
    logic [29:0]        fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]        fifo_dest_q [FIFO_DEPTH];
    logic               fifo_take_q [FIFO_DEPTH];
    logic [GHR_LEN-1:0] fifo_ghr_q  [FIFO_DEPTH];

    logic               run, empty, full, starve_hit, do_grant, do_deq, do_acc, head_wr;
    logic [29:0]        head_pc;
    logic [IDX_W-1:0]   lookup_idx, write_idx;
    logic               unused_bits;

    assign run        = state_q == S_RUN;
    assign empty      = count_q == '0;
    assign full       = count_q == CNT_W'(FIFO_DEPTH);
    assign starve_hit = !empty && starve_q == SW'(STARVE_MAX);
    assign do_grant   = run && lookup_req_i && !starve_hit;
    assign do_deq     = run && !empty && !do_grant;
    assign do_acc     = rep_valid_i && rep_ready_o;
    assign head_pc    = fifo_pc_q[rd_ptr_q];
    assign head_wr    = do_deq && fifo_take_q[rd_ptr_q];
    assign lookup_idx = lookup_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign write_idx  = head_pc[IDX_W-1:0] ^ IDX_W'(fifo_ghr_q[rd_ptr_q]);
    assign ghr_o      = ghr_q;
    assign unused_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0], rep_pc_i[1:0]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    // Leave INIT once the sweep has written the last entry.
    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT && init_cnt_q == '1) state_d = S_RUN;
    end

    // RAM port and handshake outputs; INIT forces invalidating writes.
    always_comb begin
        busy_o         = !run;
        rep_ready_o    = run && !full;
        lookup_grant_o = do_grant;
        ram_en_o       = run ? (do_grant || head_wr) : 1'b1;
        ram_we_o       = run ? head_wr : 1'b1;
        ram_idx_o      = run ? (do_grant ? lookup_idx : write_idx) : init_cnt_q;
        ram_wtag_o     = run ? head_pc[29:IDX_W] : '0;
        ram_wdata_o    = run ? fifo_dest_q[rd_ptr_q] : '0;
        ram_wvalid_o   = head_wr;
    end

    // Sweep counter, GHR, queue pointers and starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt_q <= '0;
            ghr_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
        end else begin
            if (!run) init_cnt_q <= init_cnt_q + IDX_W'(1);
            if (do_acc) ghr_q <= {rep_ghr_i[GHR_LEN-2:0], rep_take_i};
            else if (run && spec_valid_i) ghr_q <= {ghr_q[GHR_LEN-2:0], spec_take_i};
            if (do_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q  <= count_q + CNT_W'(do_acc) - CNT_W'(do_deq);
            // A non-empty queue at the limit always dequeues, so the increment self-saturates.
            starve_q <= (do_deq || empty) ? '0 : starve_q + SW'(do_grant);
        end
    end

    // Queue payload write on accept.
    always_ff @(posedge clk) begin
        if (do_acc) begin
            fifo_pc_q[wr_ptr_q]   <= rep_pc_i[31:2];
            fifo_dest_q[wr_ptr_q] <= rep_dest_i;
            fifo_take_q[wr_ptr_q] <= rep_take_i;
            fifo_ghr_q[wr_ptr_q]  <= rep_ghr_i;
        end
    end
endmodule

// File: tb/tb_ijtc_update_scheduler.sv
// tb_ijtc_update_scheduler: directed scenarios plus randomized run against a queue-level model.
module tb_ijtc_update_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_req_i, spec_valid_i, spec_take_i, rep_valid_i, rep_take_i;
    logic [31:0] lookup_pc_i, rep_pc_i, rep_dest_i;
    logic [7:0]  rep_ghr_i;
    logic        lookup_grant_o, rep_ready_o, ram_en_o, ram_we_o, ram_wvalid_o, busy_o;
    logic [7:0]  ghr_o, ram_idx_o;
    logic [21:0] ram_wtag_o;
    logic [31:0] ram_wdata_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] dest;
        logic        take;
        logic [7:0]  ghr;
    } rep_t;

    ijtc_update_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_req_i(lookup_req_i), .lookup_pc_i(lookup_pc_i), .lookup_grant_o(lookup_grant_o),
        .spec_valid_i(spec_valid_i), .spec_take_i(spec_take_i),
        .rep_valid_i(rep_valid_i), .rep_ready_o(rep_ready_o), .rep_pc_i(rep_pc_i),
        .rep_dest_i(rep_dest_i), .rep_take_i(rep_take_i), .rep_ghr_i(rep_ghr_i),
        .ghr_o(ghr_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_idx_o(ram_idx_o),
        .ram_wtag_o(ram_wtag_o), .ram_wdata_o(ram_wdata_o), .ram_wvalid_o(ram_wvalid_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        lookup_req_i = 0; lookup_pc_i = 0; spec_valid_i = 0; spec_take_i = 0;
        rep_valid_i = 0; rep_pc_i = 0; rep_dest_i = 0; rep_take_i = 0; rep_ghr_i = 0;
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 0; i < 256; i++) begin
            #1;
            n_checks++;
            if (ram_en_o !== 1 || ram_we_o !== 1 || ram_wvalid_o !== 0 || ram_idx_o !== 8'(i) ||
                rep_ready_o !== 0 || lookup_grant_o !== 0 || busy_o !== 1) begin
                n_fail++;
                $display("FAIL %s_sweep[%0d]: en=%b we=%b wv=%b idx=%h rdy=%b gnt=%b busy=%b, need 1 1 0 %h 0 0 1",
                         tag, i, ram_en_o, ram_we_o, ram_wvalid_o, ram_idx_o, rep_ready_o, lookup_grant_o, busy_o, 8'(i));
            end
            tick();
        end
        #1;
        n_checks++;
        if (busy_o !== 0 || rep_ready_o !== 1 || ghr_o !== 8'h00) begin
            n_fail++;
            $display("FAIL %s_run_entry: busy=%b rdy=%b ghr=%h, need 0 1 00", tag, busy_o, rep_ready_o, ghr_o);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #1;
        n_checks++;
        if (ram_en_o !== 1 || ram_we_o !== 1 || ram_idx_o !== 8'h00 || ram_wvalid_o !== 0 ||
            busy_o !== 1 || rep_ready_o !== 0 || lookup_grant_o !== 0 || ghr_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%b we=%b idx=%h wv=%b busy=%b rdy=%b gnt=%b ghr=%h",
                     ram_en_o, ram_we_o, ram_idx_o, ram_wvalid_o, busy_o, rep_ready_o, lookup_grant_o, ghr_o);
        end
        @(negedge clk);
        rst_n = 1;
        lookup_req_i = 1; lookup_pc_i = 32'h8000_1234;
        spec_valid_i = 1; spec_take_i = 1;
        sweep_check("init");
        idle_inputs();
    endtask

    task automatic test_lookup();
        logic [7:0] pat = 8'h5A;
        for (int b = 7; b >= 0; b--) begin
            spec_valid_i = 1; spec_take_i = pat[b];
            tick();
        end
        spec_valid_i = 0;
        lookup_req_i = 1; lookup_pc_i = 32'h8000_1234;
        #1;
        n_checks++;
        if (ghr_o !== 8'h5A) begin
            n_fail++;
            $display("FAIL lookup_ghr: got %h need 5a", ghr_o);
        end
        n_checks++;
        if (lookup_grant_o !== 1 || ram_en_o !== 1 || ram_we_o !== 0 || ram_idx_o !== 8'hD7) begin
            n_fail++;
            $display("FAIL lookup_port: gnt=%b en=%b we=%b idx=%h, need 1 1 0 d7",
                     lookup_grant_o, ram_en_o, ram_we_o, ram_idx_o);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_repair_write();
        rep_valid_i = 1; rep_pc_i = 32'hBFC0_0010; rep_dest_i = 32'h8000_0400;
        rep_take_i = 1; rep_ghr_i = 8'h03;
        #1;
        n_checks++;
        if (rep_ready_o !== 1 || ram_en_o !== 0) begin
            n_fail++;
            $display("FAIL repair_accept: rdy=%b en=%b need 1 0", rep_ready_o, ram_en_o);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (ghr_o !== 8'h07) begin
            n_fail++;
            $display("FAIL repair_ghr: got %h need 07", ghr_o);
        end
        n_checks++;
        if (ram_en_o !== 1 || ram_we_o !== 1 || ram_idx_o !== 8'h07 || ram_wtag_o !== 22'h2FF000 ||
            ram_wdata_o !== 32'h8000_0400 || ram_wvalid_o !== 1) begin
            n_fail++;
            $display("FAIL repair_write: en=%b we=%b idx=%h tag=%h data=%h wv=%b, need 1 1 07 2ff000 80000400 1",
                     ram_en_o, ram_we_o, ram_idx_o, ram_wtag_o, ram_wdata_o, ram_wvalid_o);
        end
        tick();
        #1;
        n_checks++;
        if (ram_en_o !== 0) begin
            n_fail++;
            $display("FAIL repair_once: en=%b need 0", ram_en_o);
        end
    endtask

    task automatic test_starve();
        lookup_req_i = 1; lookup_pc_i = 32'h1000_0040;
        rep_valid_i = 1; rep_pc_i = 32'h2000_0100; rep_dest_i = 32'h3000_0000; rep_take_i = 1; rep_ghr_i = 8'h11;
        tick();
        rep_valid_i = 0;
        for (int c = 1; c <= 7; c++) begin
            #1;
            n_checks++;
            if (lookup_grant_o !== 1 || ram_we_o !== 0) begin
                n_fail++;
                $display("FAIL starve_grant[%0d]: gnt=%b we=%b need 1 0", c, lookup_grant_o, ram_we_o);
            end
            tick();
        end
        #1;
        n_checks++;
        if (lookup_grant_o !== 0 || ram_we_o !== 1 || ram_wdata_o !== 32'h3000_0000) begin
            n_fail++;
            $display("FAIL starve_service: gnt=%b we=%b data=%h need 0 1 30000000", lookup_grant_o, ram_we_o, ram_wdata_o);
        end
        tick();
        #1;
        n_checks++;
        if (lookup_grant_o !== 1) begin
            n_fail++;
            $display("FAIL starve_resume: gnt=%b need 1", lookup_grant_o);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        lookup_req_i = 1; lookup_pc_i = 32'h4000_0000;
        for (int c = 0; c <= 9; c++) begin
            rep_valid_i = 1; rep_pc_i = 32'h5000_0000 + 32'(c * 4); rep_dest_i = 32'hA000_0000 + 32'(c);
            rep_take_i = (c != 0); rep_ghr_i = 8'(c);
            #1;
            n_checks++;
            if (rep_ready_o !== (c < 4 || c == 9)) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b need %b", c, rep_ready_o, (c < 4 || c == 9));
            end
            if (c == 8) begin
                n_checks++;
                if (lookup_grant_o !== 0 || ram_en_o !== 0) begin
                    n_fail++;
                    $display("FAIL b2b_nottaken: gnt=%b en=%b need 0 0", lookup_grant_o, ram_en_o);
                end
            end
            tick();
        end
        idle_inputs();
        #1;
        n_checks++;
        if (ram_we_o !== 1 || ram_wdata_o !== 32'hA000_0001) begin
            n_fail++;
            $display("FAIL b2b_drain_head: we=%b data=%h need 1 a0000001", ram_we_o, ram_wdata_o);
        end
        for (int c = 0; c < 6; c++) tick();
        #1;
        n_checks++;
        if (ram_en_o !== 0) begin
            n_fail++;
            $display("FAIL b2b_empty: en=%b need 0", ram_en_o);
        end
    endtask

    task automatic test_ghr_priority();
        rep_valid_i = 1; rep_pc_i = 32'h0000_0100; rep_dest_i = 32'h1; rep_take_i = 0; rep_ghr_i = 8'hA5;
        spec_valid_i = 1; spec_take_i = 1;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (ghr_o !== 8'h4A) begin
            n_fail++;
            $display("FAIL ghr_priority: got %h need 4a", ghr_o);
        end
        n_checks++;
        if (ram_en_o !== 0) begin
            n_fail++;
            $display("FAIL ghr_priority_nowrite: en=%b need 0", ram_en_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        lookup_req_i = 1; lookup_pc_i = 32'h6000_0000;
        for (int c = 0; c < 3; c++) begin
            rep_valid_i = 1; rep_pc_i = 32'h7000_0000 + 32'(c * 4); rep_dest_i = 32'hB000_0000; rep_take_i = 1; rep_ghr_i = 8'hFF;
            tick();
        end
        rep_valid_i = 0;
        rst_n = 0;
        #1;
        n_checks++;
        if (busy_o !== 1 || rep_ready_o !== 0 || ram_idx_o !== 8'h00 || ram_wvalid_o !== 0 || lookup_grant_o !== 0 || ghr_o !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_outputs: busy=%b rdy=%b idx=%h wv=%b gnt=%b ghr=%h",
                     busy_o, rep_ready_o, ram_idx_o, ram_wvalid_o, lookup_grant_o, ghr_o);
        end
        @(negedge clk);
        rst_n = 1;
        sweep_check("midreset");
        idle_inputs();
        #1;
        n_checks++;
        if (ram_en_o !== 0) begin
            n_fail++;
            $display("FAIL midreset_stale: en=%b need 0", ram_en_o);
        end
    endtask

    task automatic test_random();
        rep_t        q[$];
        rep_t        head;
        logic [7:0]  m_ghr = 8'h00;
        int          wait_n = 0;
        logic        e_ready, e_grant, deq, wr, acc, bad;
        for (int c = 0; c < 600; c++) begin
            lookup_req_i = ($urandom_range(0, 9) < 7); lookup_pc_i = $urandom;
            rep_valid_i = ($urandom_range(0, 9) < 4); rep_pc_i = $urandom; rep_dest_i = $urandom;
            rep_take_i = 1'($urandom_range(0, 1)); rep_ghr_i = 8'($urandom);
            spec_valid_i = 1'($urandom_range(0, 1)); spec_take_i = 1'($urandom_range(0, 1));
            #1;
            head = '{pc: 0, dest: 0, take: 0, ghr: 0};
            if (q.size() > 0) head = q[0];
            e_ready = q.size() < 4;
            e_grant = lookup_req_i && !(q.size() > 0 && wait_n == 7);
            deq     = q.size() > 0 && !e_grant;
            wr      = deq && head.take;
            bad = ghr_o !== m_ghr || rep_ready_o !== e_ready || lookup_grant_o !== e_grant ||
                  ram_en_o !== (e_grant || wr) || ram_we_o !== wr || ram_wvalid_o !== wr || busy_o !== 0;
            if (e_grant && ram_idx_o !== (lookup_pc_i[9:2] ^ m_ghr)) bad = 1;
            if (wr && (ram_idx_o !== (head.pc[9:2] ^ head.ghr) || ram_wtag_o !== head.pc[31:10] || ram_wdata_o !== head.dest)) bad = 1;
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL random[%0d]: ghr=%h/%h rdy=%b/%b gnt=%b/%b en=%b/%b we=%b/%b idx=%h tag=%h data=%h head_pc=%h head_dest=%h",
                         c, ghr_o, m_ghr, rep_ready_o, e_ready, lookup_grant_o, e_grant, ram_en_o, e_grant || wr,
                         ram_we_o, wr, ram_idx_o, ram_wtag_o, ram_wdata_o, head.pc, head.dest);
            end
            acc = rep_valid_i && e_ready;
            if (acc) m_ghr = {rep_ghr_i[6:0], rep_take_i};
            else if (spec_valid_i) m_ghr = {m_ghr[6:0], spec_take_i};
            if (deq || q.size() == 0) wait_n = 0;
            else if (e_grant) wait_n++;
            if (deq) void'(q.pop_front());
            if (acc) q.push_back('{pc: rep_pc_i, dest: rep_dest_i, take: rep_take_i, ghr: rep_ghr_i});
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 8; c++) tick();
    endtask

    initial begin
        test_reset();
        test_lookup();
        test_repair_write();
        test_starve();
        test_back_to_back();
        test_ghr_priority();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ijtc_update_scheduler.md
# ijtc_update_scheduler

Owns the single-port IJTC target RAM. It arbitrates between fetch-stage lookups and buffered backend repair writes, and maintains the global history register (GHR) used for the Gshare index. After reset it sweeps the table invalid, then services lookups with priority while draining repairs through a small FIFO. A starvation guard bounds how long a repair can wait behind lookups. It sits between the fetch-stage IJTC query path and the branch-status-check (BSC) repair path.

## Interface
- FIFO_DEPTH, 4, repair queue entries (power of two)
- GHR_LEN, 8, history bits; must be ≤ IDX_W
- IDX_W, 8, RAM index width; table holds 2^IDX_W entries
- STARVE_MAX, 7, consecutive lookup grants tolerated while a repair waits
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- lookup_req_i  in  1  fetch wants a table read this cycle (index accepted and request active)
- lookup_pc_i  in  32  fetch-group PC
- lookup_grant_o  out  1  lookup owns the RAM this cycle
- spec_valid_i  in  1  frontend speculative direction update
- spec_take_i  in  1  predicted direction shifted into GHR
- rep_valid_i / rep_ready_o  in/out  1  repair handshake
- rep_pc_i  in  32  PC of mispredicted jump
- rep_dest_i  in  32  correct target
- rep_take_i  in  1  correct direction
- rep_ghr_i  in  GHR_LEN  checkpointed GHR at prediction time
- ghr_o  out  GHR_LEN  current GHR
- ram_en_o, ram_we_o  out  1  RAM enable / write enable
- ram_idx_o  out  IDX_W  RAM index
- ram_wtag_o  out  30-IDX_W  write tag = pc[31:IDX_W+2]
- ram_wdata_o  out  32  write target
- ram_wvalid_o  out  1  valid bit written
- busy_o  out  1  high during INIT

## Operation
- Hash: idx = pc[IDX_W+1:2] XOR zero-extended GHR.
- Lookups use ghr_o. Writes use the entry's stored rep_ghr.
- FSM INIT (reset state):
  - ram_en=1, ram_we=1, ram_wvalid=0, ram_idx = init counter.
  - rep_ready_o=0, lookup_grant_o=0, busy_o=1. spec updates are ignored.
  - Counter increments each cycle. When it reaches 2^IDX_W−1, the next state is RUN.
- RUN: rep_ready_o = !full. Per-cycle priority:
  - (a) FIFO non-empty and starve==STARVE_MAX → service head.
  - (b) lookup_req_i → grant lookup: ram_en=1, we=0.
  - (c) FIFO non-empty → service head.
  - (d) otherwise ram_en=0.
- Servicing the head dequeues it in one cycle:
  - take=1 → write (we=1, wvalid=1, wtag, wdata=dest).
  - take=0 → dequeue with ram_en=0; a not-taken jump never writes.
- Starve counter:
  - Increments (saturating) on each lookup grant while the FIFO is non-empty.
  - Clears on any dequeue or when the FIFO is empty.
- GHR update on repair accept (rep_valid & rep_ready): ghr ← {rep_ghr[GHR_LEN-2:0], rep_take}.
- GHR update otherwise, in RUN when spec_valid: ghr ← {ghr[GHR_LEN-2:0], spec_take}.
- Repair accept wins over spec_valid in the same cycle; the spec update is dropped.
- Enqueue and dequeue in the same cycle are both honoured. rep_ready_o is computed from pre-cycle full only, with no pass-through when full.

## Timing
- Reset values: state INIT, init counter 0, GHR 0, FIFO empty, starve 0.
- Outputs during reset: ram_en=1, ram_we=1, ram_idx=0, wvalid=0, busy=1, rep_ready=0, lookup_grant=0.
- Async assertion mid-operation discards queued repairs and restarts INIT.
- INIT lasts exactly 2^IDX_W cycles after reset release.
- lookup_grant_o and all RAM outputs are combinational from state and inputs in the same cycle. Read data is RAM latency, outside this block.
- A repair accepted in cycle N is eligible for dequeue in N+1 at the earliest; there is no bypass.
- GHR changes are visible on ghr_o in the cycle after the update.
- Worst-case wait for the FIFO head under continuous lookups is STARVE_MAX+1 cycles.

## Test plan
- Reset release, IDX_W=8 → 256 cycles of writes at idx 0x00..0xFF with wvalid=0 and rep_ready=0; cycle 257: busy_o=0, rep_ready_o=1.
- RUN, ghr_o=0x5A, lookup_req=1, pc=0x8000_1234 → lookup_grant=1, we=0, ram_idx=0xD7.
- Repair pc=0xBFC0_0010, dest=0x8000_0400, take=1, ghr=0x03, lookup idle:
  - Next cycle: ghr_o=0x07.
  - Same next cycle: write at idx=0x07, wtag=0x2FF000, wdata=0x8000_0400, wvalid=1.
- lookup_req held high, one repair accepted at cycle 0 → grants in cycles 1–7, update in cycle 8 (lookup_grant=0), grants resume in cycle 9.
- lookup_req held high, five back-to-back repairs → four accepted, then rep_ready=0 until the first dequeue (cycle 8). A take=0 entry dequeues with ram_en=0.
- Repair accept and spec_valid=1 in the same cycle → ghr_o reflects the repair only.
- rst pulse while the FIFO holds 3 entries → FIFO empties, INIT sweep restarts at idx 0, no stale writes occur.
